// File: rtl/sram_lsu_ctrl.sv
// Single-outstanding load/store controller in front of a simple dual-port SRAM.
// Partial writes are done as a read-modify-write of the addressed word.
module sram_lsu_ctrl #(
  parameter int RD_LATENCY = 1
) (
  input  logic        clka,
  input  logic        rstb,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        sram_wea,
  output logic [31:0] sram_waddr,
  output logic [31:0] sram_dina,
  output logic [31:0] sram_addra,
  input  logic [31:0] sram_douta
);

  typedef enum logic [2:0] {IDLE, RD_WAIT, RMW_RD, RMW_WR, WR} state_t;

  localparam logic [1:0] LAT = 2'(RD_LATENCY);

  state_t      state_reg;
  logic [1:0]  lat_cnt_reg;
  logic [3:0]  be_reg;
  logic [31:0] wdata_reg;
  logic [31:0] merged;
  logic [31:0] word_addr;
  logic        accept;
  logic        unused_addr_bits;

  assign req_ready        = (state_reg == IDLE) && !rstb;
  assign accept           = req_valid && req_ready;
  assign word_addr        = {2'b00, req_addr[31:2]};
  assign unused_addr_bits = ^req_addr[1:0];

  // Byte merge of captured write data over the old word returned by the SRAM.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_merge
      assign merged[8*gi +: 8] = be_reg[gi] ? wdata_reg[8*gi +: 8] : sram_douta[8*gi +: 8];
    end
  endgenerate

  always_ff @(posedge clka) begin
    if (rstb) begin
      state_reg   <= IDLE;
      lat_cnt_reg <= '0;
      be_reg      <= '0;
      wdata_reg   <= '0;
      resp_valid  <= 1'b0;
      resp_rdata  <= '0;
      sram_wea    <= 1'b0;
      sram_waddr  <= '0;
      sram_dina   <= '0;
      sram_addra  <= '0;
    end else begin
      resp_valid <= 1'b0;
      sram_wea   <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            be_reg      <= req_be;
            wdata_reg   <= req_wdata;
            lat_cnt_reg <= '0;
            if (!req_we) begin
              sram_addra <= word_addr;
              state_reg  <= RD_WAIT;
            end else if (req_be == 4'hF) begin
              sram_wea   <= 1'b1;
              sram_waddr <= word_addr;
              sram_dina  <= req_wdata;
              resp_valid <= 1'b1;
              resp_rdata <= '0;
              state_reg  <= WR;
            end else if (req_be == 4'h0) begin
              resp_valid <= 1'b1;
              resp_rdata <= '0;
              state_reg  <= WR;
            end else begin
              sram_addra <= word_addr;
              state_reg  <= RMW_RD;
            end
          end
        end
        RD_WAIT: begin
          if (lat_cnt_reg == LAT) begin
            resp_valid <= 1'b1;
            resp_rdata <= sram_douta;
            state_reg  <= IDLE;
          end else begin
            lat_cnt_reg <= lat_cnt_reg + 2'd1;
          end
        end
        RMW_RD: begin
          // sram_addra still holds the target word, reuse it as the write address.
          if (lat_cnt_reg == LAT) begin
            sram_wea   <= 1'b1;
            sram_waddr <= sram_addra;
            sram_dina  <= merged;
            resp_valid <= 1'b1;
            resp_rdata <= '0;
            state_reg  <= RMW_WR;
          end else begin
            lat_cnt_reg <= lat_cnt_reg + 2'd1;
          end
        end
        RMW_WR:  state_reg <= IDLE;
        WR:      state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_lsu_ctrl.sv
// Bench for sram_lsu_ctrl: instance A (latency 1) with a shadow memory model,
// instance B (latency 2) for back-to-back reads with response timing checks.
module tb_sram_lsu_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstb;
  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Instance A signals
  logic        a_req_valid, a_req_ready, a_req_we;
  logic [3:0]  a_req_be;
  logic [31:0] a_req_addr, a_req_wdata;
  logic        a_resp_valid;
  logic [31:0] a_resp_rdata;
  logic        a_sram_wea;
  logic [31:0] a_sram_waddr, a_sram_dina, a_sram_addra, a_sram_douta;

  // Instance B signals
  logic        b_req_valid, b_req_ready;
  logic [31:0] b_req_addr;
  logic        b_resp_valid;
  logic [31:0] b_resp_rdata;
  logic        b_sram_wea;
  logic [31:0] b_sram_waddr, b_sram_dina, b_sram_addra, b_sram_douta;

  sram_lsu_ctrl #(.RD_LATENCY(1)) dut_a (
    .clka(clk), .rstb(rstb),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
    .req_be(a_req_be), .req_addr(a_req_addr), .req_wdata(a_req_wdata),
    .resp_valid(a_resp_valid), .resp_rdata(a_resp_rdata),
    .sram_wea(a_sram_wea), .sram_waddr(a_sram_waddr), .sram_dina(a_sram_dina),
    .sram_addra(a_sram_addra), .sram_douta(a_sram_douta)
  );

  sram_lsu_ctrl #(.RD_LATENCY(2)) dut_b (
    .clka(clk), .rstb(rstb),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(1'b0),
    .req_be(4'h0), .req_addr(b_req_addr), .req_wdata(32'h0),
    .resp_valid(b_resp_valid), .resp_rdata(b_resp_rdata),
    .sram_wea(b_sram_wea), .sram_waddr(b_sram_waddr), .sram_dina(b_sram_dina),
    .sram_addra(b_sram_addra), .sram_douta(b_sram_douta)
  );

  // SRAM models
  logic [31:0] mem_a [0:255];
  logic [31:0] ref_a [0:255];
  logic [31:0] mem_b [0:255];
  logic [31:0] a_dout_q, b_dout_q1, b_dout_q2;

  always @(posedge clk) begin
    if (a_sram_wea) mem_a[a_sram_waddr[7:0]] <= a_sram_dina;
    a_dout_q  <= mem_a[a_sram_addra[7:0]];
    b_dout_q1 <= mem_b[b_sram_addra[7:0]];
    b_dout_q2 <= b_dout_q1;
  end
  assign a_sram_douta = a_dout_q;
  assign b_sram_douta = b_dout_q2;

  // Scoreboards
  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic [31:0] exp_a [$];
  exp_t        exp_b [$];

  always @(negedge clk) begin
    if (a_resp_valid) begin
      checks++;
      if (exp_a.size() == 0) begin
        fails++;
        $display("FAIL a_unexpected_resp: got resp_valid=1 rdata=%h, required no response", a_resp_rdata);
      end else begin
        logic [31:0] e;
        e = exp_a.pop_front();
        if (a_resp_rdata !== e) begin
          fails++;
          $display("FAIL a_resp_rdata: got %h, required %h", a_resp_rdata, e);
        end else
          $display("A resp rdata=%h at cycle %0d", a_resp_rdata, cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (b_sram_wea) begin
      checks++;
      fails++;
      $display("FAIL b_sram_wea: got 1 during reads, required 0");
    end
    if (b_resp_valid) begin
      checks++;
      if (exp_b.size() == 0) begin
        fails++;
        $display("FAIL b_unexpected_resp: got rdata=%h, required no response", b_resp_rdata);
      end else begin
        exp_t e;
        e = exp_b.pop_front();
        if (b_resp_rdata !== e.data || cyc != e.cyc) begin
          fails++;
          $display("FAIL b_resp: got rdata=%h cycle=%0d, required rdata=%h cycle=%0d",
                   b_resp_rdata, cyc, e.data, e.cyc);
        end else
          $display("B resp rdata=%h at cycle %0d", b_resp_rdata, cyc);
      end
    end
  end

  // Issue one request on A; returns 1ns after the accepting edge (cycle T+1).
  task automatic issue_a(input logic we, input logic [3:0] be, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic expect_resp);
    int n;
    int w;
    logic [31:0] e;
    @(negedge clk);
    a_req_valid = 1'b1; a_req_we = we; a_req_be = be;
    a_req_addr = addr; a_req_wdata = wdata;
    n = 0;
    while (!a_req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!a_req_ready) begin
      fails++;
      $display("FAIL a_accept_timeout: got req_ready=0 for 50 cycles, required 1");
      a_req_valid = 1'b0;
      return;
    end
    w = int'(addr[9:2]);
    if (expect_resp) begin
      if (!we) e = ref_a[w];
      else begin
        e = 32'h0;
        for (int i = 0; i < 4; i++)
          if (be[i]) ref_a[w][8*i +: 8] = wdata[8*i +: 8];
      end
      exp_a.push_back(e);
    end
    $display("A accept we=%0b be=%h addr=%h wdata=%h at cycle %0d", we, be, addr, wdata, cyc);
    @(posedge clk);
    #1;
    a_req_valid = 1'b0;
    a_req_we = $urandom_range(0, 1);
    a_req_addr = $urandom;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_a.size() != 0 || exp_b.size() != 0 || !a_req_ready) && n < 60) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 60) begin
      fails++;
      $display("FAIL drain_timeout: got %0d/%0d pending, required 0/0", exp_a.size(), exp_b.size());
    end
  endtask

  task automatic test_reset();
    rstb = 1'b1;
    repeat (3) @(negedge clk);
    checks += 8;
    if (a_req_ready !== 1'b0) begin fails++; $display("FAIL rst_req_ready: got %b, required 0", a_req_ready); end
    if (b_req_ready !== 1'b0) begin fails++; $display("FAIL rst_b_req_ready: got %b, required 0", b_req_ready); end
    if (a_resp_valid !== 1'b0) begin fails++; $display("FAIL rst_resp_valid: got %b, required 0", a_resp_valid); end
    if (a_resp_rdata !== 32'h0) begin fails++; $display("FAIL rst_resp_rdata: got %h, required 0", a_resp_rdata); end
    if (a_sram_wea !== 1'b0) begin fails++; $display("FAIL rst_wea: got %b, required 0", a_sram_wea); end
    if (a_sram_waddr !== 32'h0) begin fails++; $display("FAIL rst_waddr: got %h, required 0", a_sram_waddr); end
    if (a_sram_dina !== 32'h0) begin fails++; $display("FAIL rst_dina: got %h, required 0", a_sram_dina); end
    if (a_sram_addra !== 32'h0) begin fails++; $display("FAIL rst_addra: got %h, required 0", a_sram_addra); end
    rstb = 1'b0;
    #1;
    checks++;
    if (a_req_ready !== 1'b1) begin fails++; $display("FAIL rst_release_ready: got %b, required 1", a_req_ready); end
    $display("reset checked at cycle %0d", cyc);
  endtask

  task automatic test_full_write();
    issue_a(1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 1'b1);
    @(negedge clk);  // T+1
    checks += 5;
    if (a_sram_wea !== 1'b1) begin fails++; $display("FAIL fw_wea: got %b, required 1", a_sram_wea); end
    if (a_sram_waddr !== 32'h4) begin fails++; $display("FAIL fw_waddr: got %h, required 4", a_sram_waddr); end
    if (a_sram_dina !== 32'hDEADBEEF) begin fails++; $display("FAIL fw_dina: got %h, required deadbeef", a_sram_dina); end
    if (a_resp_valid !== 1'b1) begin fails++; $display("FAIL fw_resp_valid: got %b, required 1", a_resp_valid); end
    if (a_req_ready !== 1'b0) begin fails++; $display("FAIL fw_busy_ready: got %b, required 0", a_req_ready); end
    @(negedge clk);  // T+2
    checks += 2;
    if (a_req_ready !== 1'b1) begin fails++; $display("FAIL fw_ready_t2: got %b, required 1", a_req_ready); end
    if (a_sram_wea !== 1'b0) begin fails++; $display("FAIL fw_wea_t2: got %b, required 0", a_sram_wea); end
  endtask

  task automatic test_read();
    issue_a(1'b0, 4'h0, 32'h10, 32'h0, 1'b1);
    @(negedge clk);  // T+1
    checks += 2;
    if (a_sram_addra !== 32'h4) begin fails++; $display("FAIL rd_addra: got %h, required 4", a_sram_addra); end
    if (a_resp_valid !== 1'b0) begin fails++; $display("FAIL rd_early_t1: got resp_valid=%b, required 0", a_resp_valid); end
    @(negedge clk);  // T+2
    checks++;
    if (a_resp_valid !== 1'b0) begin fails++; $display("FAIL rd_early_t2: got resp_valid=%b, required 0", a_resp_valid); end
    @(negedge clk);  // T+3
    checks += 2;
    if (a_resp_valid !== 1'b1) begin fails++; $display("FAIL rd_resp_t3: got resp_valid=%b, required 1", a_resp_valid); end
    if (a_resp_rdata !== 32'hDEADBEEF) begin fails++; $display("FAIL rd_rdata_t3: got %h, required deadbeef", a_resp_rdata); end
    @(negedge clk);  // T+4
    checks += 2;
    if (a_resp_valid !== 1'b0) begin fails++; $display("FAIL rd_resp_t4: got resp_valid=%b, required 0", a_resp_valid); end
    if (a_resp_rdata !== 32'hDEADBEEF) begin fails++; $display("FAIL rd_hold_t4: got %h, required deadbeef", a_resp_rdata); end
  endtask

  task automatic test_partial_write();
    int wea_cnt;
    int wea_at;
    logic [31:0] dina_seen;
    logic [31:0] waddr_seen;
    issue_a(1'b1, 4'hF, 32'h20, 32'h11223344, 1'b1);
    issue_a(1'b1, 4'b0010, 32'h20, 32'h0000AA00, 1'b1);
    wea_cnt = 0; wea_at = -1; dina_seen = 32'h0; waddr_seen = 32'h0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (a_sram_wea) begin
        wea_cnt++; wea_at = k; dina_seen = a_sram_dina; waddr_seen = a_sram_waddr;
      end
    end
    checks += 4;
    if (wea_cnt != 1) begin fails++; $display("FAIL pw_wea_count: got %0d, required 1", wea_cnt); end
    if (wea_at != 3) begin fails++; $display("FAIL pw_wea_cycle: got T+%0d, required T+3", wea_at); end
    if (dina_seen !== 32'h1122AA44) begin fails++; $display("FAIL pw_dina: got %h, required 1122aa44", dina_seen); end
    if (waddr_seen !== 32'h8) begin fails++; $display("FAIL pw_waddr: got %h, required 8", waddr_seen); end
    issue_a(1'b0, 4'h0, 32'h20, 32'h0, 1'b1);
    wait_drain();
  endtask

  task automatic test_null_write();
    issue_a(1'b1, 4'h0, 32'h20, 32'hFFFFFFFF, 1'b1);
    @(negedge clk);  // T+1
    checks += 3;
    if (a_resp_valid !== 1'b1) begin fails++; $display("FAIL nw_resp_valid: got %b, required 1", a_resp_valid); end
    if (a_resp_rdata !== 32'h0) begin fails++; $display("FAIL nw_rdata: got %h, required 0", a_resp_rdata); end
    if (a_sram_wea !== 1'b0) begin fails++; $display("FAIL nw_wea_t1: got %b, required 0", a_sram_wea); end
    @(negedge clk);  // T+2
    checks += 2;
    if (a_sram_wea !== 1'b0) begin fails++; $display("FAIL nw_wea_t2: got %b, required 0", a_sram_wea); end
    if (a_req_ready !== 1'b1) begin fails++; $display("FAIL nw_ready_t2: got %b, required 1", a_req_ready); end
    issue_a(1'b0, 4'h0, 32'h20, 32'h0, 1'b1);
    wait_drain();
  endtask

  task automatic test_reset_abort();
    int wea_cnt;
    int resp_cnt;
    issue_a(1'b1, 4'b0100, 32'h30, 32'h00550000, 1'b0);
    wea_cnt = 0; resp_cnt = 0;
    @(negedge clk);  // T+1
    wea_cnt += a_sram_wea; resp_cnt += a_resp_valid;
    @(negedge clk);  // T+2
    wea_cnt += a_sram_wea; resp_cnt += a_resp_valid;
    rstb = 1'b1;
    @(negedge clk);  // T+3
    wea_cnt += a_sram_wea; resp_cnt += a_resp_valid;
    rstb = 1'b0;
    #1;
    checks++;
    if (a_req_ready !== 1'b1) begin fails++; $display("FAIL ab_ready_after_rst: got %b, required 1", a_req_ready); end
    repeat (3) begin
      @(negedge clk);
      wea_cnt += a_sram_wea; resp_cnt += a_resp_valid;
    end
    checks += 2;
    if (wea_cnt != 0) begin fails++; $display("FAIL ab_wea: got %0d write cycles, required 0", wea_cnt); end
    if (resp_cnt != 0) begin fails++; $display("FAIL ab_resp: got %0d responses, required 0", resp_cnt); end
    issue_a(1'b0, 4'h0, 32'h30, 32'h0, 1'b1);
    wait_drain();
  endtask

  task automatic test_random();
    logic [3:0] be;
    for (int k = 0; k < 24; k++) begin
      be = 4'($urandom_range(0, 15));
      if (k % 6 == 0) be = 4'hF;
      if (k % 6 == 1) be = 4'h0;
      issue_a(1'($urandom_range(0, 1)), be,
              {26'h0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))}, $urandom, 1'b1);
    end
    wait_drain();
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [3];
    logic [31:0] datas [3];
    int acc [3];
    int k;
    int n;
    exp_t e;
    addrs[0] = 32'h4;  addrs[1] = 32'h8;  addrs[2] = 32'hC;
    datas[0] = 32'hA5A5_0001; datas[1] = 32'h5A5A_0002; datas[2] = 32'h0F0F_0003;
    acc[0] = 0; acc[1] = 0; acc[2] = 0;
    @(negedge clk);
    b_req_valid = 1'b1;
    b_req_addr = addrs[0];
    k = 0; n = 0;
    while (k < 3 && n < 60) begin
      if (b_req_ready) begin
        acc[k] = cyc;
        e.data = datas[k];
        e.cyc = cyc + 4;
        exp_b.push_back(e);
        $display("B accept addr=%h at cycle %0d", b_req_addr, cyc);
        k++;
        @(posedge clk);
        #1;
        if (k < 3) b_req_addr = addrs[k];
        else b_req_valid = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    b_req_valid = 1'b0;
    checks += 3;
    if (k != 3) begin fails++; $display("FAIL b2b_accepts: got %0d, required 3", k); end
    if (acc[1] - acc[0] != 4) begin fails++; $display("FAIL b2b_gap01: got %0d, required 4", acc[1] - acc[0]); end
    if (acc[2] - acc[1] != 4) begin fails++; $display("FAIL b2b_gap12: got %0d, required 4", acc[2] - acc[1]); end
    wait_drain();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = 32'h0;
      ref_a[i] = 32'h0;
      mem_b[i] = 32'h0;
    end
    mem_b[1] = 32'hA5A5_0001;
    mem_b[2] = 32'h5A5A_0002;
    mem_b[3] = 32'h0F0F_0003;
    rstb = 1'b1;
    a_req_valid = 1'b0; a_req_we = 1'b0; a_req_be = 4'h0;
    a_req_addr = 32'h0; a_req_wdata = 32'h0;
    b_req_valid = 1'b0; b_req_addr = 32'h0;

    test_reset();
    test_full_write();
    test_read();
    test_partial_write();
    test_null_write();
    test_reset_abort();
    test_random();
    test_back_to_back();

    repeat (3) @(negedge clk);
    checks++;
    if (exp_a.size() != 0 || exp_b.size() != 0) begin
      fails++;
      $display("FAIL final_queues: got %0d/%0d pending, required 0/0", exp_a.size(), exp_b.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/sram_lsu_ctrl.md
SRAM_LSU_CTRL -- requirements
Module: sram_lsu_ctrl

Interface
REQ-001 The block SHALL have parameter: RD_LATENCY, 1, SRAM read latency in cycles from sram_addra to sram_douta; legal values 1 and 2.
REQ-002 The block SHALL have port: clka  input  1  single clock; all logic on rising edge.
REQ-003 The block SHALL have port: rstb  input  1  reset, synchronous, active-high.
REQ-004 The block SHALL have port: req_valid  input  1  CPU request valid.
REQ-005 The block SHALL have port: req_ready  output  1  controller can accept a request.
REQ-006 The block SHALL have port: req_we  input  1  1 = write, 0 = read.
REQ-007 The block SHALL have port: req_be  input  4  byte enables for writes; bit i covers data bits [8i+7:8i]; ignored for reads.
REQ-008 The block SHALL have port: req_addr  input  32  byte address; bits [1:0] ignored.
REQ-009 The block SHALL have port: req_wdata  input  32  write data.
REQ-010 The block SHALL have port: resp_valid  output  1  one-cycle completion pulse, once per accepted request.
REQ-011 The block SHALL have port: resp_rdata  output  32  read data; 0 for write responses.
REQ-012 The block SHALL have port: sram_wea  output  1  SRAM write enable, word-wide.
REQ-013 The block SHALL have port: sram_waddr  output  32  SRAM write word address.
REQ-014 The block SHALL have port: sram_dina  output  32  SRAM write data.
REQ-015 The block SHALL have port: sram_addra  output  32  SRAM read word address.
REQ-016 The block SHALL have port: sram_douta  input  32  SRAM read data.

Function
REQ-017 Word address SHALL be {2'b00, req_addr[31:2]}, driven on sram_waddr/sram_addra.
REQ-018 States SHALL be IDLE, RD_WAIT, RMW_RD, RMW_WR, WR; req_ready = 1 only in IDLE with rstb low.
REQ-019 Accept SHALL occur in cycle T when req_valid && req_ready; all req_* fields captured at T; inputs outside accept cycles ignored.
REQ-020 Full write (we=1, be=4'hF): IDLE->WR; in T+1 sram_wea=1, sram_waddr/sram_dina = captured values, resp_valid=1; IDLE at T+2.
REQ-021 Null write (we=1, be=0): no SRAM write; resp_valid=1 in T+1; IDLE at T+2.
REQ-022 Read (we=0): IDLE->RD_WAIT; sram_addra held from T+1; sram_douta registered in cycle T+1+RD_LATENCY; resp_valid=1 with resp_rdata=that value in T+2+RD_LATENCY; then IDLE.
REQ-023 Partial write (we=1, be not 0/F): RMW_RD reads old word as in REQ-022; RMW_WR in T+2+RD_LATENCY drives sram_wea=1, sram_dina byte i = be[i] ? wdata byte i : old byte i, resp_valid=1 same cycle; then IDLE.
REQ-024 sram_wea SHALL be 1 only in the single write cycle of REQ-020/023; never in reads or null writes.
REQ-025 Exactly one outstanding request; req_valid held high while busy SHALL NOT be accepted until IDLE.
REQ-026 A read accepted after a write's resp_valid SHALL return the written data (writes complete before the next accept).
REQ-027 resp_rdata SHALL hold its last value between responses; write responses drive 0.
REQ-028 Unused address/data outputs SHALL hold their last values.

Reset
REQ-029 With rstb high at a clock edge: state=IDLE, resp_valid=0, resp_rdata=0, sram_wea=0, sram_waddr=0, sram_dina=0, sram_addra=0; req_ready=0 while rstb high.
REQ-030 Reset during any non-IDLE state SHALL abort the request: no SRAM write, no resp_valid; req_ready=1 in first cycle after rstb low.

Verification
REQ-031 RD_LATENCY=1, full write addr 0x10 data 0xDEADBEEF accepted at T -> T+1: sram_wea=1, sram_waddr=0x4, sram_dina=0xDEADBEEF, resp_valid=1; req_ready=1 at T+2.
REQ-032 Then read addr 0x10 accepted at T -> sram_addra=0x4 from T+1; resp_valid=1, resp_rdata=0xDEADBEEF at T+3 only.
REQ-033 Word at 0x20 = 0x11223344; write be=4'b0010, wdata 0x0000AA00 at T -> sram_wea=1 only at T+3, sram_dina=0x1122AA44, one resp_valid.
REQ-034 Write be=0 at T -> no sram_wea, resp_valid at T+1, resp_rdata=0.
REQ-035 rstb high at T+2 during partial write -> sram_wea stays 0, no resp_valid; req_ready=1 in first cycle after rstb low.
REQ-036 RD_LATENCY=2, req_valid held high with three reads -> each resp at accept+4, req_ready low while busy, three responses in order.
